// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Valid/ready handshake on input and output; optional two's-complement input.
module bin2bcd_seq #(
   parameter int unsigned BIN_W  = 9,
   parameter int unsigned DIGITS = 3,
   parameter int unsigned SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  ovf
);

   localparam int unsigned CW = $clog2(BIN_W + 1);
   localparam logic [CW-1:0] LastCnt = CW'(BIN_W - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [BIN_W-1:0]     sr_q, sr_d;
   logic [4*DIGITS-1:0]  dig_q, dig_d;
   logic [4*DIGITS-1:0]  adj;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic                 ovf_q, ovf_d;
   logic                 in_neg;
   logic [BIN_W-1:0]     mag;

   // Most-negative input wraps to 2^(BIN_W-1), which still fits as unsigned.
   assign in_neg = (SIGNED != 0) && bin[BIN_W-1];
   assign mag    = in_neg ? (~bin + BIN_W'(1)) : bin;

   always_comb begin
      for (int i = 0; i < int'(DIGITS); i++) begin
         adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StShift;
               sr_d    = mag;
               dig_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               neg_d   = in_neg;
            end
         end
         StShift: begin
            dig_d = {adj[4*DIGITS-2:0], sr_q[BIN_W-1]};
            // Bit leaving the top digit means the value needs more digits.
            if (adj[4*DIGITS-1]) ovf_d = 1'b1;
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastCnt) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sr_q    <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = (state_q == StDone);
   assign bcd       = dig_q;
   assign neg       = neg_q;
   assign ovf       = ovf_q;

endmodule
